link_tx_scheduler: RTL and testbench
====================================

# link_tx_scheduler

Per-link transmit scheduler between one ARQ block's tx side and the physical link word stream. It enforces credit-based flow control towards the neighbour's receive buffer and returns local credits in-band. It shares the single tx link between ARQ data words and locally generated credit-return words. One instance sits per cardinal port in the mesh top, downstream of `arq_wrap`.

## Interface
- `WORD_WIDTH`, default `fatmeshy_pkg::LINK_WORD_SIZE`: link word width.
- `INIT_CREDITS`, default 16: far-end receive buffer depth; credit counter value after reset.
- `CREDIT_THRESHOLD`, default 4: pending local credits that make a return due.
- `FLUSH_TIMEOUT`, default 64: cycles a nonzero pending count may wait below threshold before a return is due.
- `MAX_DEFER`, default 8: cycles a due credit return may lose arbitration before it is forced.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset; asynchronous, active-high.
- `data_valid` input 1: ARQ offers a data word.
- `data_word` input `WORD_WIDTH`: ARQ word.
- `data_prio` input 1: word is a retransmission.
- `data_accept` output 1: word taken this cycle.
- `credit_rx_valid` input 1: neighbour returned credits.
- `credit_rx_value` input `CREDIT_WIDTH`: number of credits returned.
- `rx_consumed` input 1: local receive buffer freed one slot this cycle.
- `tx_valid` output 1: link word present.
- `tx_data` output `WORD_WIDTH`: link word.
- `tx_is_credit` output 1: word is a credit return, not data.
- `tx_ready` input 1: link consumes the word.
- `credits_available` output `CREDIT_WIDTH`: current far-end credits.
- `pending_return` output `CREDIT_WIDTH`: local credits not yet returned.

## Operation
- Output slot is one register; `slot_free = !tx_valid || tx_ready`.
- When `tx_valid && !tx_ready`, `tx_data` and `tx_is_credit` hold stable.
- `credit_due` is true when:
  - `pending_return >= CREDIT_THRESHOLD`, or
  - `pending_return != 0` and the flush timer reached `FLUSH_TIMEOUT`.
- Defer counter:
  - Increments each cycle `credit_due` is true but not granted.
  - Clears on a credit grant.
  - `force_credit = defer_cnt >= MAX_DEFER`.
- Grant priority when `slot_free`:
  1. `force_credit`
  2. prio data
  3. `credit_due`
  4. normal data
- A data grant requires `credits_available != 0`.
- `data_accept = slot_free && data_valid && credits_available != 0 && data granted`; combinational, low during reset.
- Credit grant loads the slot:
  - `tx_data = {zeros, pending_return}`, `tx_is_credit = 1`.
  - The snapshot value is subtracted from the accumulator.
  - A same-cycle `rx_consumed` is added, so the next value is `0 + rx_consumed`.
- Credit counter update: next = current + (`credit_rx_valid ? credit_rx_value : 0`) − `data_accept`.
  - Saturates at `2^CREDIT_WIDTH − 1`; never underflows, because accept requires nonzero credits.
- Accumulator:
  - +1 per `rx_consumed`, saturating at max.
  - Flush timer runs while pending is nonzero and no credit is granted; clears otherwise.
- Outputs after reset:
  - `tx_valid=0`, `tx_data=0`, `tx_is_credit=0`.
  - `credits_available=INIT_CREDITS`, `pending_return=0`.
  - Timers and defer counter are 0.
- Reset mid-transfer discards the slot word; ARQ retransmits it.

## Timing
- Grant to `tx_valid` takes 1 cycle; the slot register is loaded on the accept edge.
- Back-to-back throughput is one word per cycle while `tx_ready=1` and credits remain.
- `credit_rx_valid` affects `data_accept` in the following cycle.
- Credits reaching 0 blocks data in the next cycle; credit-return words are still sent.
- The flush timer compares with `>=`; a return becomes due `FLUSH_TIMEOUT` cycles after the first unreturned credit.

## Configuration
- `LINK_TX_SCHEDULER_STATS_EN` defined adds three 32-bit wrapping output counters:
  - `stat_data_words`: data words sent.
  - `stat_credit_words`: credit words sent.
  - `stat_stall_cycles`: `data_valid` high with zero credits.
- The counters reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Structure
- `fatmeshy_pkg` holds:
  - `credit_t` / `CREDIT_WIDTH`.
  - `link_tx_kind` enum {`TX_DATA`, `TX_CREDIT`}.
  - The stats counter width constant.
- Sub-module `credit_return_accumulator` contains the pending count, flush timer and `credit_due` generation.
- Arbitration, the credit counter and the output slot live in the top-level module.

## Test plan
- Reset, then `data_valid=1`, `tx_ready=1` continuously → exactly 16 accepts, `credits_available` reaches 0, `data_accept` stays low afterwards.
- At 0 credits, `credit_rx_valid=1` with `credit_rx_value=3` → exactly 3 further data words accepted, starting the cycle after the return.
- 4 `rx_consumed` pulses with data idle → credit word with `tx_data[7:0]=4` and `tx_is_credit=1`; `pending_return` returns to 0.
- 1 `rx_consumed` pulse, no further activity → credit word of value 1 appears 64 cycles later (±1 for register stage).
- Continuous prio data with 5 pending credits → credit word forced after 8 deferred cycles, then prio data resumes.
- `tx_ready=0` for 10 cycles with `tx_valid=1` → `tx_data` stable, no accepts; assert `rst` mid-stall → `tx_valid=0` and `credits_available=16` immediately.

Source files
------------

// File: rtl/fatmeshy_pkg.sv
// Shared link-level types and constants for the fatmeshy mesh.
package fatmeshy_pkg;

    localparam int unsigned LINK_WORD_SIZE = 32;
    localparam int unsigned CREDIT_WIDTH   = 8;
    localparam int unsigned STAT_WIDTH     = 32;

    typedef logic [CREDIT_WIDTH-1:0] credit_t;
    typedef logic [STAT_WIDTH-1:0]   stat_t;

    localparam credit_t CREDIT_MAX = '1;
    localparam credit_t CREDIT_ONE = credit_t'(1);
    localparam stat_t   STAT_ONE   = stat_t'(1);

    // Kind of word currently held in a link tx slot.
    typedef enum logic {
        TX_DATA   = 1'b0,
        TX_CREDIT = 1'b1
    } link_tx_kind;

endpackage

// File: rtl/credit_return_accumulator.sv
// Counts locally freed receive slots not yet returned to the neighbour and
// decides when a credit-return word is due (threshold reached or the oldest
// unreturned credit has waited FLUSH_TIMEOUT cycles).
module credit_return_accumulator
    import fatmeshy_pkg::*;
#(
    parameter int unsigned CREDIT_THRESHOLD = 4,
    parameter int unsigned FLUSH_TIMEOUT    = 64
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rx_consumed,
    input  logic    credit_grant,
    output credit_t pending,
    output logic    credit_due
);

    localparam int unsigned TW = (FLUSH_TIMEOUT < 1) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(FLUSH_TIMEOUT);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
    localparam credit_t       THRESHOLD   = credit_t'(CREDIT_THRESHOLD);

    credit_t       pending_q, pending_d;
    logic [TW-1:0] timer_q, timer_d;

    // Next pending count and flush timer; a grant returns the whole snapshot.
    always_comb begin
        pending_d = pending_q;
        if (credit_grant) begin
            pending_d = rx_consumed ? CREDIT_ONE : '0;
        end else if (rx_consumed && (pending_q != CREDIT_MAX)) begin
            pending_d = pending_q + CREDIT_ONE;
        end
        timer_d = '0;
        if ((pending_q != '0) && !credit_grant) begin
            timer_d = (timer_q >= TIMER_LIMIT) ? timer_q : timer_q + TIMER_ONE;
        end
    end

    // Pending count and flush timer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            timer_q   <= '0;
        end else begin
            pending_q <= pending_d;
            timer_q   <= timer_d;
        end
    end

    assign pending    = pending_q;
    assign credit_due = (pending_q >= THRESHOLD) ||
                        ((pending_q != '0) && (timer_q >= TIMER_LIMIT));

endmodule

// File: rtl/link_tx_scheduler.sv
// Per-link transmit scheduler: shares one tx link between ARQ data words and
// local credit-return words, and enforces far-end credit flow control.
// Define LINK_TX_SCHEDULER_STATS_EN to add data/credit/stall statistics counters.
module link_tx_scheduler
    import fatmeshy_pkg::*;
#(
    parameter int unsigned WORD_WIDTH       = LINK_WORD_SIZE,
    parameter int unsigned INIT_CREDITS     = 16,
    parameter int unsigned CREDIT_THRESHOLD = 4,
    parameter int unsigned FLUSH_TIMEOUT    = 64,
    parameter int unsigned MAX_DEFER        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [WORD_WIDTH-1:0] data_word,
    input  logic                  data_prio,
    output logic                  data_accept,
    input  logic                  credit_rx_valid,
    input  credit_t               credit_rx_value,
    input  logic                  rx_consumed,
    output logic                  tx_valid,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_is_credit,
    input  logic                  tx_ready,
    output credit_t               credits_available,
    output credit_t               pending_return
`ifdef LINK_TX_SCHEDULER_STATS_EN
    ,
    output stat_t                 stat_data_words,
    output stat_t                 stat_credit_words,
    output stat_t                 stat_stall_cycles
`endif
);

    localparam int unsigned DW = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);
    localparam logic [DW-1:0] DEFER_LIMIT = DW'(MAX_DEFER);
    localparam logic [DW-1:0] DEFER_ONE   = DW'(1);
    localparam credit_t       INIT_CRED   = credit_t'(INIT_CREDITS);

    logic                  tx_valid_q, tx_valid_d;
    logic [WORD_WIDTH-1:0] tx_data_q, tx_data_d;
    link_tx_kind           tx_kind_q, tx_kind_d;
    credit_t               credits_q, credits_d;
    logic [DW-1:0]         defer_q, defer_d;
    logic [CREDIT_WIDTH:0] credit_sum;

    logic    slot_free, credits_ok, credit_due, force_credit, prio_ready;
    logic    grant_credit, grant_data;
    credit_t pending;

    credit_return_accumulator #(
        .CREDIT_THRESHOLD (CREDIT_THRESHOLD),
        .FLUSH_TIMEOUT    (FLUSH_TIMEOUT)
    ) u_accum (
        .clk          (clk),
        .rst          (rst),
        .rx_consumed  (rx_consumed),
        .credit_grant (grant_credit),
        .pending      (pending),
        .credit_due   (credit_due)
    );

    assign slot_free    = !tx_valid_q || tx_ready;
    assign credits_ok   = (credits_q != '0);
    assign force_credit = (defer_q >= DEFER_LIMIT);
    assign prio_ready   = data_valid && data_prio && credits_ok;
    // Forced credit beats prio data; a merely due credit only beats normal data.
    assign grant_credit = slot_free && credit_due && (force_credit || !prio_ready);
    assign grant_data   = slot_free && !grant_credit && data_valid && credits_ok;
    assign data_accept  = grant_data && !rst;

    // Next slot, credit counter and defer counter.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_kind_d  = tx_kind_q;
        if (slot_free) begin
            tx_valid_d = grant_credit || grant_data;
            if (grant_credit) begin
                tx_data_d = WORD_WIDTH'(pending);
                tx_kind_d = TX_CREDIT;
            end else if (grant_data) begin
                tx_data_d = data_word;
                tx_kind_d = TX_DATA;
            end
        end

        credit_sum = {1'b0, credits_q}
                   + {1'b0, (credit_rx_valid ? credit_rx_value : credit_t'(0))}
                   - {{CREDIT_WIDTH{1'b0}}, data_accept};
        if (credit_sum > {1'b0, CREDIT_MAX}) begin
            credits_d = CREDIT_MAX;
        end else begin
            credits_d = credit_sum[CREDIT_WIDTH-1:0];
        end

        defer_d = defer_q;
        if (grant_credit) begin
            defer_d = '0;
        end else if (credit_due && (defer_q != '1)) begin
            defer_d = defer_q + DEFER_ONE;
        end
    end

    // Output slot, far-end credits and defer counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_kind_q  <= TX_DATA;
            credits_q  <= INIT_CRED;
            defer_q    <= '0;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_kind_q  <= tx_kind_d;
            credits_q  <= credits_d;
            defer_q    <= defer_d;
        end
    end

    assign tx_valid          = tx_valid_q;
    assign tx_data           = tx_data_q;
    assign tx_is_credit      = (tx_kind_q == TX_CREDIT);
    assign credits_available = credits_q;
    assign pending_return    = pending;

`ifdef LINK_TX_SCHEDULER_STATS_EN
    stat_t stat_data_q, stat_credit_q, stat_stall_q;

    // Wrapping statistics counters; words count on the link handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_data_q   <= '0;
            stat_credit_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (tx_valid_q && tx_ready && (tx_kind_q == TX_DATA)) begin
                stat_data_q <= stat_data_q + STAT_ONE;
            end
            if (tx_valid_q && tx_ready && (tx_kind_q == TX_CREDIT)) begin
                stat_credit_q <= stat_credit_q + STAT_ONE;
            end
            if (data_valid && !credits_ok) begin
                stat_stall_q <= stat_stall_q + STAT_ONE;
            end
        end
    end

    assign stat_data_words   = stat_data_q;
    assign stat_credit_words = stat_credit_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Scoreboard bench for link_tx_scheduler: stimulus pushes expected link words,
// a negedge monitor pops and compares every word the link consumes.
module tb_link_tx_scheduler;
    import fatmeshy_pkg::*;

    localparam int unsigned W = LINK_WORD_SIZE;

    logic         clk = 1'b0;
    logic         rst;
    logic         data_valid, data_prio, data_accept;
    logic [W-1:0] data_word;
    logic         credit_rx_valid, rx_consumed;
    credit_t      credit_rx_value;
    logic         tx_valid, tx_is_credit, tx_ready;
    logic [W-1:0] tx_data;
    credit_t      credits_available, pending_return;

    int total = 0;
    int bad   = 0;
    logic [W:0] exp_q[$];

    link_tx_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .data_valid        (data_valid),
        .data_word         (data_word),
        .data_prio         (data_prio),
        .data_accept       (data_accept),
        .credit_rx_valid   (credit_rx_valid),
        .credit_rx_value   (credit_rx_value),
        .rx_consumed       (rx_consumed),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_is_credit      (tx_is_credit),
        .tx_ready          (tx_ready),
        .credits_available (credits_available),
        .pending_return    (pending_return)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed link word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected actual=%0h required=none", {tx_is_credit, tx_data});
            end else begin
                check("tx_word", {31'b0, tx_is_credit, tx_data}, {31'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst             = 1'b1;
        data_valid      = 1'b1;
        data_prio       = 1'b0;
        data_word       = '0;
        credit_rx_valid = 1'b0;
        credit_rx_value = '0;
        rx_consumed     = 1'b0;
        tx_ready        = 1'b1;

        // Reset state, accept held low during reset.
        @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_is_credit", tx_is_credit, 0);
        check("rst_credits", credits_available, 16);
        check("rst_pending", pending_return, 0);
        check("rst_accept", data_accept, 0);
        next_cycle();
        rst = 1'b0;

        // Exactly 16 accepts with continuous data, then blocked.
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, W'(32'h100 + i)});
        for (int i = 0; i < 20; i++) begin
            data_word = W'(32'h100 + i);
            @(negedge clk);
            check("a_accept", data_accept, (i < 16) ? 1 : 0);
            next_cycle();
        end
        check("a_credits_zero", credits_available, 0);

        // Return of 3 credits: accepts on the following three cycles only.
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, W'(32'h201 + i)});
        for (int j = 0; j < 6; j++) begin
            data_word       = W'(32'h200 + j);
            credit_rx_valid = (j == 0);
            credit_rx_value = 8'd3;
            @(negedge clk);
            check("b_accept", data_accept, (j >= 1 && j <= 3) ? 1 : 0);
            next_cycle();
        end
        credit_rx_valid = 1'b0;
        data_valid      = 1'b0;
        next_cycle();
        check("b_credits_zero", credits_available, 0);

        // Four consumed slots reach the threshold: credit word of value 4.
        exp_q.push_back({1'b1, W'(4)});
        for (int k = 0; k < 4; k++) begin
            rx_consumed = 1'b1;
            next_cycle();
        end
        rx_consumed = 1'b0;
        check("c_pending_4", pending_return, 4);
        next_cycle();
        check("c_tx_credit", {tx_valid, tx_is_credit}, 2'b11);
        check("c_pending_0", pending_return, 0);
        next_cycle();

        // Single consumed slot is flushed by the timeout.
        exp_q.push_back({1'b1, W'(1)});
        rx_consumed = 1'b1;
        next_cycle();
        rx_consumed = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (tx_valid && tx_is_credit) break;
            next_cycle();
            n++;
        end
        total++;
        if (n < 64 || n > 65) begin
            bad++;
            $display("FAIL d_flush_latency actual=%0d required=64..65", n);
        end
        next_cycle();
        next_cycle();

        // Prio data starves a due credit until it is forced after 8 deferrals.
        credit_rx_valid = 1'b1;
        credit_rx_value = 8'd20;
        next_cycle();
        credit_rx_valid = 1'b0;
        check("e_credits_20", credits_available, 20);
        for (int c = 0; c < 16; c++) begin
            if (c == 12) exp_q.push_back({1'b1, W'(5)});
            else         exp_q.push_back({1'b0, W'(32'h300 + c)});
        end
        data_valid = 1'b1;
        data_prio  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            data_word   = W'(32'h300 + c);
            rx_consumed = (c < 5);
            @(negedge clk);
            check("e_accept", data_accept, (c == 12) ? 0 : 1);
            next_cycle();
        end
        rx_consumed = 1'b0;
        data_valid  = 1'b0;
        data_prio   = 1'b0;
        next_cycle();
        next_cycle();
        check("e_credits_5", credits_available, 5);
        check("e_pending_0", pending_return, 0);

        // Stall: slot holds while tx_ready is low, reset discards it.
        tx_ready   = 1'b0;
        data_valid = 1'b1;
        data_word  = W'(32'h4AA);
        @(negedge clk);
        check("f_load_accept", data_accept, 1);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            data_word = W'(32'h500 + i);
            @(negedge clk);
            check("f_stall_hold", {tx_valid, data_accept, tx_data}, {1'b1, 1'b0, W'(32'h4AA)});
            next_cycle();
        end
        rst = 1'b1;
        #1;
        check("f_rst_tx_valid", tx_valid, 0);
        check("f_rst_credits", credits_available, 16);
        check("f_rst_accept", data_accept, 0);
        next_cycle();
        rst        = 1'b0;
        data_valid = 1'b0;
        tx_ready   = 1'b1;
        next_cycle();
        next_cycle();

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
